// File: rtl/split_sampler_pkg.sv
// Shared types and constants for split_sampler: FSM states, candidate packing
// layout of the six checker variables, LFSR seed/taps and small helpers.
package split_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } sampler_state_t;

  localparam int W_V15  = 15;
  localparam int W_V49  = 5;
  localparam int W_V70  = 8;
  localparam int W_V73  = 12;
  localparam int W_V115 = 5;
  localparam int W_V116 = 5;

  localparam int O_V15  = 0;
  localparam int O_V49  = 15;
  localparam int O_V70  = 20;
  localparam int O_V73  = 28;
  localparam int O_V115 = 40;
  localparam int O_V116 = 45;

  localparam int CAND_W = 50;
  typedef logic [CAND_W-1:0] cand_t;

  localparam logic [63:0] DEFAULT_SEED = 64'hACE1_5EED_0F0F_1234;
  // Right-shifting Galois form of x^64 + x^63 + x^61 + x^60 + 1
  localparam logic [63:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/split_sampler_if.sv
// Handshake and candidate bus between the sampler, its requester, the
// downstream consumer and the combinational split checker.
interface split_sampler_if;
  import split_pkg::*;

  logic              start;
  logic              seed_load;
  logic [63:0]       seed;
  logic              sat_x;
  logic [W_V15-1:0]  var_15;
  logic [W_V49-1:0]  var_49;
  logic [W_V70-1:0]  var_70;
  logic [W_V73-1:0]  var_73;
  logic [W_V115-1:0] var_115;
  logic [W_V116-1:0] var_116;
  logic              busy;
  logic              out_valid;
  logic              out_fail;
  logic              out_ready;
  logic [15:0]       try_count;

  modport master (
    output start, seed_load, seed, sat_x, out_ready,
    input  var_15, var_49, var_70, var_73, var_115, var_116,
           busy, out_valid, out_fail, try_count
  );

  modport slave (
    input  start, seed_load, seed, sat_x, out_ready,
    output var_15, var_49, var_70, var_73, var_115, var_116,
           busy, out_valid, out_fail, try_count
  );
endinterface

// File: rtl/split_sampler_lfsr64.sv
// 64-bit Galois LFSR with synchronous load; a zero load value is replaced by
// SEED so the register can never lock up in the all-zero state.
module lfsr64
  import split_pkg::*;
#(
  parameter logic [63:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        step,
  output logic [63:0] state
);

  logic [63:0] state_d, state_q;

  always_comb begin
    state_d = state_q;
    if (load) state_d = (load_val == '0) ? SEED : load_val;
    if (step) state_d = lfsr_step(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/split_sampler.sv
// Random accept/reject sampler feeding the constraint-split checker.
// Optional counters stat_req/stat_fail/stat_tries under SPLIT_SAMPLER_STATS_EN.
module split_sampler
  import split_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 1024,
  parameter logic [63:0] SEED      = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  split_sampler_if.slave  sif
`ifdef SPLIT_SAMPLER_STATS_EN
  ,
  output logic [31:0]     stat_req,
  output logic [31:0]     stat_fail,
  output logic [31:0]     stat_tries
`endif
);

  localparam logic [15:0] MAX_T = 16'(MAX_TRIES);

  sampler_state_t state_d, state_q;
  logic [15:0]    try_d, try_q;
  cand_t          cand_d, cand_q, cand_nxt;
  logic [63:0]    lfsr_state;
  logic           lfsr_load, lfsr_adv;

  assign lfsr_load = (state_q == ST_IDLE) && sif.seed_load;
  assign lfsr_adv  = (state_q == ST_GEN);

  lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (sif.seed),
    .step     (lfsr_adv),
    .state    (lfsr_state)
  );

  // Candidate is taken from the post-step LFSR value, the same one the
  // LFSR register captures on this GEN edge.
  assign cand_nxt = cand_t'(lfsr_step(lfsr_state));

  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    cand_d  = cand_q;
    case (state_q)
      ST_IDLE: if (sif.start) begin
        state_d = ST_GEN;
        try_d   = '0;
      end
      ST_GEN: begin
        state_d = ST_CHECK;
        try_d   = try_q + 16'd1;
        cand_d  = cand_nxt;
      end
      ST_CHECK: begin
        if (sif.sat_x)           state_d = ST_DONE;
        else if (try_q == MAX_T) state_d = ST_FAIL;
        else                     state_d = ST_GEN;
      end
      ST_DONE, ST_FAIL: if (sif.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      try_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      try_q   <= try_d;
      cand_q  <= cand_d;
    end
  end

  assign sif.var_15    = cand_q[O_V15  +: W_V15];
  assign sif.var_49    = cand_q[O_V49  +: W_V49];
  assign sif.var_70    = cand_q[O_V70  +: W_V70];
  assign sif.var_73    = cand_q[O_V73  +: W_V73];
  assign sif.var_115   = cand_q[O_V115 +: W_V115];
  assign sif.var_116   = cand_q[O_V116 +: W_V116];
  assign sif.busy      = (state_q == ST_GEN) || (state_q == ST_CHECK);
  assign sif.out_valid = (state_q == ST_DONE) || (state_q == ST_FAIL);
  assign sif.out_fail  = (state_q == ST_FAIL);
  assign sif.try_count = try_q;

`ifdef SPLIT_SAMPLER_STATS_EN
  logic [31:0] req_d, req_q, fail_d, fail_q, tries_d, tries_q;

  always_comb begin
    req_d   = req_q;
    fail_d  = fail_q;
    tries_d = tries_q;
    if (state_q == ST_IDLE && sif.start)          req_d   = sat_inc(req_q);
    if (state_q == ST_CHECK && state_d == ST_FAIL) fail_d  = sat_inc(fail_q);
    if (state_q == ST_GEN)                         tries_d = sat_inc(tries_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      fail_q  <= '0;
      tries_q <= '0;
    end else begin
      req_q   <= req_d;
      fail_q  <= fail_d;
      tries_q <= tries_d;
    end
  end

  assign stat_req   = req_q;
  assign stat_fail  = fail_q;
  assign stat_tries = tries_q;
`endif

endmodule

// File: tb/tb_split_sampler.sv
// Directed bench for split_sampler: default-budget instance plus a
// MAX_TRIES=4 instance; LFSR steps after the default seed are hand-derived.
module tb_split_sampler;
  import split_pkg::*;

  // Hand-derived Galois steps (taps D800...) from 64'hACE15EED0F0F1234
  localparam logic [63:0] S1     = 64'h5670_AF76_8787_891A;
  localparam logic [63:0] S3     = 64'hCD9C_2BDD_A1E1_E246;
  localparam logic [63:0] S4     = 64'h66CE_15EE_D0F0_F123;
  localparam logic [63:0] S_ONE1 = 64'hD800_0000_0000_0000;
  localparam logic [63:0] SEED0  = 64'hACE1_5EED_0F0F_1234;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  split_sampler_if sif ();
  split_sampler_if sif4 ();

`ifdef SPLIT_SAMPLER_STATS_EN
  logic [31:0] s_req, s_fail, s_tries, s4_req, s4_fail, s4_tries;
`endif

  split_sampler #(.MAX_TRIES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
`ifdef SPLIT_SAMPLER_STATS_EN
    ,
    .stat_req   (s_req),
    .stat_fail  (s_fail),
    .stat_tries (s_tries)
`endif
  );

  split_sampler #(.MAX_TRIES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .sif (sif4)
`ifdef SPLIT_SAMPLER_STATS_EN
    ,
    .stat_req   (s4_req),
    .stat_fail  (s4_fail),
    .stat_tries (s4_tries)
`endif
  );

  logic [49:0] cand;
  assign cand = {sif.var_116, sif.var_115, sif.var_73, sif.var_70, sif.var_49, sif.var_15};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic consume();
    sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sif.start = 0;  sif.seed_load = 0;  sif.seed = '0;  sif.sat_x = 0;  sif.out_ready = 0;
    sif4.start = 0; sif4.seed_load = 0; sif4.seed = '0; sif4.sat_x = 0; sif4.out_ready = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();

    chk("rst_valid", sif.out_valid, 0);
    chk("rst_fail",  sif.out_fail, 0);
    chk("rst_busy",  sif.busy, 0);
    chk("rst_try",   sif.try_count, 0);
    chk("rst_cand",  cand, 0);
    chk("rst_lfsr",  dut.u_lfsr.state, SEED0);

    // success on try 3: edges 0..6, result seen by the edge-7 sample
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    repeat (5) tick();
    chk("t3_pre_valid", sif.out_valid, 0);
    chk("t3_pre_busy",  sif.busy, 1);
    sif.sat_x = 1'b1; tick(); sif.sat_x = 1'b0;
    chk("t3_valid", sif.out_valid, 1);
    chk("t3_fail",  sif.out_fail, 0);
    chk("t3_try",   sif.try_count, 3);
    chk("t3_busy",  sif.busy, 0);
    chk("t3_cand",  cand, S3[49:0]);

    // hold with out_ready low; stray start/seed_load must be ignored
    for (int i = 0; i < 10; i++) begin
      sif.start     = (i % 3 == 0);
      sif.seed_load = (i == 4);
      sif.seed      = 64'h1;
      tick();
    end
    sif.start = 1'b0; sif.seed_load = 1'b0; sif.seed = '0;
    chk("hold_valid", sif.out_valid, 1);
    chk("hold_cand",  cand, S3[49:0]);
    chk("hold_try",   sif.try_count, 3);
    consume();
    chk("cons_valid", sif.out_valid, 0);
    chk("cons_busy",  sif.busy, 0);

    // next request continues the sequence: candidate is step 4
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    tick();
    sif.sat_x = 1'b1; tick(); sif.sat_x = 1'b0;
    chk("t4_valid", sif.out_valid, 1);
    chk("t4_try",   sif.try_count, 1);
    chk("t4_cand",  cand, S4[49:0]);
    consume();

    // seed 0 with start: falls back to the default seed
    sif.seed = '0; sif.seed_load = 1'b1; sif.start = 1'b1; tick();
    sif.seed_load = 1'b0; sif.start = 1'b0;
    tick();
    sif.sat_x = 1'b1; tick(); sif.sat_x = 1'b0;
    chk("seed0_cand", cand, S1[49:0]);
    chk("seed0_try",  sif.try_count, 1);
    consume();

    // seed 1 with start
    sif.seed = 64'h1; sif.seed_load = 1'b1; sif.start = 1'b1; tick();
    sif.seed_load = 1'b0; sif.start = 1'b0; sif.seed = '0;
    tick();
    sif.sat_x = 1'b1; tick(); sif.sat_x = 1'b0;
    chk("seed1_cand",  cand, S_ONE1[49:0]);
    chk("seed1_lfsr",  dut.u_lfsr.state, S_ONE1);
    chk("seed1_valid", sif.out_valid, 1);
    consume();

    // budget exhaustion on the MAX_TRIES=4 instance
    sif4.start = 1'b1; tick(); sif4.start = 1'b0;
    repeat (7) tick();
    chk("f4_pre_valid", sif4.out_valid, 0);
    tick();
    chk("f4_valid", sif4.out_valid, 1);
    chk("f4_fail",  sif4.out_fail, 1);
    chk("f4_try",   sif4.try_count, 4);
    sif4.out_ready = 1'b1; tick(); sif4.out_ready = 1'b0;
    chk("f4_cons", sif4.out_valid, 0);

    // reset during CHECK of try 2
    sif.start = 1'b1; tick(); sif.start = 1'b0;
    repeat (3) tick();
    chk("rq_busy", sif.busy, 1);
    chk("rq_try",  sif.try_count, 2);
`ifdef SPLIT_SAMPLER_STATS_EN
    chk("st_req",   s_req, 5);
    chk("st_tries", s_tries, 8);
    chk("st_fail",  s_fail, 0);
    chk("st4_fail", s4_fail, 1);
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rq_rst_busy",  sif.busy, 0);
    chk("rq_rst_valid", sif.out_valid, 0);
    chk("rq_rst_try",   sif.try_count, 0);
    chk("rq_rst_cand",  cand, 0);
    chk("rq_rst_lfsr",  dut.u_lfsr.state, SEED0);
    sif.sat_x = 1'b1;
    repeat (3) tick();
    sif.sat_x = 1'b0;
    chk("rq_idle_valid", sif.out_valid, 0);
    chk("rq_idle_busy",  sif.busy, 0);
`ifdef SPLIT_SAMPLER_STATS_EN
    chk("st_req_rst", s_req, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
